// File: rtl/gate_op_arbiter_pkg.sv
// Shared op codes and FSM state encoding for the gate op arbiter and its bench.
package gate_op_arbiter_pkg;

    localparam logic [1:0] OP_NAND = 2'b00;
    localparam logic [1:0] OP_NOR  = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_XNOR = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StResp = 2'b10
    } state_e;

endpackage

// File: rtl/gate_op_arbiter_if.sv
// Request/response bundle: two op requesters in, one result channel out.
interface gate_op_arbiter_if #(
    parameter int unsigned WIDTH = 4
);

    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_y;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_y
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_y
    );

endinterface

// File: rtl/gate_op_arbiter_gate_unit.sv
// Purely combinational bitwise NAND/NOR/XOR/XNOR unit.
module gate_unit
    import gate_op_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        unique case (op)
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter sharing one gate_unit between two requesters.
// Optional per-requester completion counters when GATE_ARB_STATS_EN is defined.
module gate_op_arbiter
    import gate_op_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    gate_op_arbiter_if.slave  bus,
    output logic              busy
`ifdef GATE_ARB_STATS_EN
    ,
    output logic [7:0]        cnt0,
    output logic [7:0]        cnt1
`endif
);

    state_e           state;
    logic             prio;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             id_q;
    logic [WIDTH-1:0] gate_y;
    logic             grant0;
    logic             grant1;

    assign grant0 = bus.req0_valid && (!bus.req1_valid || !prio);
    assign grant1 = bus.req1_valid && (!bus.req0_valid || prio);

    // Ready is suppressed while rst is high so nothing is accepted during reset.
    assign bus.req0_ready = !rst && (state == StIdle) && grant0;
    assign bus.req1_ready = !rst && (state == StIdle) && grant1;
    assign busy           = (state != StIdle);

    gate_unit #(
        .WIDTH (WIDTH)
    ) u_gate_unit (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (gate_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= StIdle;
            prio          <= 1'b0;
            op_q          <= 2'b00;
            a_q           <= '0;
            b_q           <= '0;
            id_q          <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_y     <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (grant0) begin
                        op_q  <= bus.req0_op;
                        a_q   <= bus.req0_a;
                        b_q   <= bus.req0_b;
                        id_q  <= 1'b0;
                        state <= StExec;
                    end else if (grant1) begin
                        op_q  <= bus.req1_op;
                        a_q   <= bus.req1_a;
                        b_q   <= bus.req1_b;
                        id_q  <= 1'b1;
                        state <= StExec;
                    end
                end
                StExec: begin
                    bus.rsp_y     <= gate_y;
                    bus.rsp_id    <= id_q;
                    bus.rsp_valid <= 1'b1;
                    state         <= StResp;
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        prio          <= ~bus.rsp_id;
                        state         <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef GATE_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= 8'h00;
            cnt1 <= 8'h00;
        end else if (state == StResp && bus.rsp_ready) begin
            if (!bus.rsp_id && cnt0 != 8'hFF) cnt0 <= cnt0 + 8'd1;
            if (bus.rsp_id && cnt1 != 8'hFF)  cnt1 <= cnt1 + 8'd1;
        end
    end
`endif

endmodule
